// File: rtl/cache_pkg.sv
// Shared constants, FSM encoding and sizing helper for the memory-port arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cache_pkg;

  localparam int DEF_WIDTH       = 32;  // byte-address width
  localparam int DEF_OFFSET_BITS = 4;   // 16-byte cache line
  localparam int DEF_BURST_LEN   = 4;   // beats per line transfer
  localparam int BEAT_BYTES      = 4;   // one 32-bit word per beat

  // Width of a counter that indexes BURST_LEN beats; never narrower than 1 bit.
  function automatic int beat_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of the shared memory port.
// Latency: none (wiring only).
// Backpressure: requesters hold req_valid until req_done; memory stalls via mem_ready.
interface mem_port_arbiter_if
  import cache_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int BEAT_W  = beat_cnt_w(DEF_BURST_LEN)
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_write;
  logic [NUM_REQ-1:0]       req_burst;
  logic [NUM_REQ*WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]       req_grant;
  logic [NUM_REQ-1:0]       req_done;
  logic                     beat_valid;
  logic [BEAT_W-1:0]        beat_idx;
  logic                     mem_read;
  logic                     mem_write;
  logic [WIDTH-1:0]         mem_addr;
  logic                     mem_ready;
  logic                     busy;

  // Arbiter side: drives grants and the memory strobes.
  modport master (
    input  req_valid, req_write, req_burst, req_addr, mem_ready,
    output req_grant, req_done, beat_valid, beat_idx,
    output mem_read, mem_write, mem_addr, busy
  );

  // Environment side: cache requesters plus main memory.
  modport slave (
    output req_valid, req_write, req_burst, req_addr, mem_ready,
    input  req_grant, req_done, beat_valid, beat_idx,
    input  mem_read, mem_write, mem_addr, busy
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request scanning up from ptr_i, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the pick is taken.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   idx_o
);

  localparam int CW = PTR_W + 1;

  logic [CW-1:0] cand;
  logic          found;

  // Walk the requesters starting at ptr_i; the sum stays below 2*NUM_REQ so one subtract wraps it.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = {1'b0, ptr_i} + CW'(off);
      if (cand >= CW'(NUM_REQ)) begin
        cand = cand - CW'(NUM_REQ);
      end
      if (!found && req_i[cand[PTR_W-1:0]]) begin
        found                    = 1'b1;
        gnt_o[cand[PTR_W-1:0]]   = 1'b1;
        idx_o                    = cand[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the main-memory port; sequences single-word or full-line transfers.
// Latency: grant and strobe one cycle after req_valid; one beat per mem_ready; one IDLE cycle between transactions.
// Backpressure: strobes and address hold until mem_ready; other requesters wait for IDLE.
module mem_port_arbiter
  import cache_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int NUM_REQ     = 2,
  parameter int OFFSET_BITS = DEF_OFFSET_BITS,
  parameter int BURST_LEN   = DEF_BURST_LEN
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus
);

  localparam int PTR_W     = $clog2(NUM_REQ);
  localparam int BW        = beat_cnt_w(BURST_LEN);
  localparam int WORD_SH   = $clog2(BEAT_BYTES);
  localparam logic [WIDTH-1:0] LINE_MASK = ~WIDTH'((1 << OFFSET_BITS) - 1);
  localparam logic [WIDTH-1:0] WORD_MASK = ~WIDTH'(BEAT_BYTES - 1);

  arb_state_e         state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [BW-1:0]      beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               wr_q, wr_d;
  logic               burst_q, burst_d;
  logic [WIDTH-1:0]   base_q, base_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [PTR_W-1:0]   pick_idx;
  logic [WIDTH-1:0]   win_addr;
  logic               last_beat;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req_i (bus.req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  assign win_addr  = bus.req_addr[int'(pick_idx)*WIDTH +: WIDTH];
  assign last_beat = burst_q ? (beat_cnt_q == BW'(BURST_LEN - 1)) : (beat_cnt_q == '0);

  // State and transaction registers; reset aborts any transfer without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
      grant_q    <= '0;
      wr_q       <= 1'b0;
      burst_q    <= 1'b0;
      base_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      grant_q    <= grant_d;
      wr_q       <= wr_d;
      burst_q    <= burst_d;
      base_q     <= base_d;
    end
  end

  // Next-state and port outputs: arbitrate in IDLE, step beats on mem_ready in XFER.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    owner_d        = owner_q;
    beat_cnt_d     = beat_cnt_q;
    grant_d        = grant_q;
    wr_d           = wr_q;
    burst_d        = burst_q;
    base_d         = base_q;
    bus.req_grant  = grant_q;
    bus.req_done   = '0;
    bus.beat_valid = 1'b0;
    bus.beat_idx   = beat_cnt_q;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = '0;
    bus.busy       = 1'b0;

    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          state_d    = XFER;
          grant_d    = pick_gnt;
          owner_d    = pick_idx;
          wr_d       = bus.req_write[pick_idx];
          burst_d    = bus.req_burst[pick_idx];
          base_d     = bus.req_burst[pick_idx] ? (win_addr & LINE_MASK) : (win_addr & WORD_MASK);
          beat_cnt_d = '0;
        end
      end
      XFER: begin
        bus.busy      = 1'b1;
        bus.mem_read  = ~wr_q;
        bus.mem_write = wr_q;
        // Beat offset never leaves the line, so OR-ing cannot carry into tag/index bits.
        bus.mem_addr  = base_q | (WIDTH'(beat_cnt_q) << WORD_SH);
        if (bus.mem_ready) begin
          bus.beat_valid = 1'b1;
          if (last_beat) begin
            bus.req_done = grant_q;
            state_d      = IDLE;
            beat_cnt_d   = '0;
            grant_d      = '0;
            rr_ptr_d     = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for the memory-port arbiter (two requesters, 4-beat lines).
// Latency: expectations are cycle-exact relative to the driving edge.
// Backpressure: mem_ready is driven per scenario to stall or stream beats.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  mem_port_arbiter_if #(.NUM_REQ(2), .WIDTH(32), .BEAT_W(2)) bus ();

  mem_port_arbiter #(
    .WIDTH       (32),
    .NUM_REQ     (2),
    .OFFSET_BITS (4),
    .BURST_LEN   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic v, input logic w, input logic b, input logic [31:0] a);
    bus.req_valid[i]         = v;
    bus.req_write[i]         = w;
    bus.req_burst[i]         = b;
    bus.req_addr[i*32 +: 32] = a;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.req_valid = 2'b11;
    bus.req_write = 2'b00;
    bus.req_burst = 2'b00;
    bus.req_addr  = '0;
    bus.mem_ready = 1'b1;
    cyc();
    cyc();
    checks++;
    if ({bus.req_grant, bus.req_done, bus.beat_valid, bus.mem_read, bus.mem_write, bus.busy} !== 8'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected %b",
               {bus.req_grant, bus.req_done, bus.beat_valid, bus.mem_read, bus.mem_write, bus.busy}, 8'b0);
    end
    checks++;
    if (bus.mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_addr: got %h expected %h", bus.mem_addr, 32'h0);
    end
    checks++;
    if (bus.beat_idx !== 2'd0) begin
      errors++;
      $display("FAIL reset_beat_idx: got %0d expected 0", bus.beat_idx);
    end
    bus.req_valid = 2'b00;
    bus.mem_ready = 1'b0;
    rst           = 1'b0;
    cyc();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_busy: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_single_read();
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h1236);
    #1;
    checks++;
    if ({bus.busy, bus.req_grant} !== 3'b000) begin
      errors++;
      $display("FAIL single_same_cycle: got %b expected %b", {bus.busy, bus.req_grant}, 3'b000);
    end
    cyc();
    checks++;
    if ({bus.req_grant, bus.mem_read, bus.mem_write} !== 4'b0110) begin
      errors++;
      $display("FAIL single_grant: got %b expected %b", {bus.req_grant, bus.mem_read, bus.mem_write}, 4'b0110);
    end
    checks++;
    if (bus.mem_addr !== 32'h1234) begin
      errors++;
      $display("FAIL single_addr: got %h expected %h", bus.mem_addr, 32'h1234);
    end
    cyc();
    checks++;
    if ({bus.mem_read, bus.beat_valid} !== 2'b10) begin
      errors++;
      $display("FAIL single_stall: got %b expected %b", {bus.mem_read, bus.beat_valid}, 2'b10);
    end
    cyc();
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if ({bus.mem_read, bus.beat_valid, bus.req_done} !== 4'b1101) begin
      errors++;
      $display("FAIL single_done: got %b expected %b", {bus.mem_read, bus.beat_valid, bus.req_done}, 4'b1101);
    end
    cyc();
    bus.mem_ready = 1'b0;
    set_req(0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    checks++;
    if ({bus.busy, bus.mem_read} !== 2'b00) begin
      errors++;
      $display("FAIL single_idle_after: got %b expected %b", {bus.busy, bus.mem_read}, 2'b00);
    end
  endtask

  task automatic test_burst_refill();
    set_req(1, 1'b1, 1'b0, 1'b1, 32'h0000_ABCC);
    cyc();
    for (int b = 0; b < 4; b++) begin
      bus.mem_ready = 1'b0;
      #1;
      checks++;
      if (bus.mem_addr !== 32'h0000_ABC0 + 32'(b * 4) || bus.beat_idx !== 2'(b) ||
          {bus.beat_valid, bus.req_done, bus.mem_read} !== 4'b0001) begin
        errors++;
        $display("FAIL burst_wait_beat%0d: got addr=%h idx=%0d bv/done/rd=%b expected addr=%h idx=%0d bv/done/rd=0001",
                 b, bus.mem_addr, bus.beat_idx, {bus.beat_valid, bus.req_done, bus.mem_read},
                 32'h0000_ABC0 + 32'(b * 4), b);
      end
      cyc();
      bus.mem_ready = 1'b1;
      #1;
      checks++;
      if (bus.beat_valid !== 1'b1 || bus.req_done !== ((b == 3) ? 2'b10 : 2'b00) ||
          bus.mem_addr !== 32'h0000_ABC0 + 32'(b * 4)) begin
        errors++;
        $display("FAIL burst_ready_beat%0d: got bv=%b done=%b addr=%h expected bv=1 done=%b addr=%h",
                 b, bus.beat_valid, bus.req_done, bus.mem_addr,
                 (b == 3) ? 2'b10 : 2'b00, 32'h0000_ABC0 + 32'(b * 4));
      end
      cyc();
    end
    bus.mem_ready = 1'b0;
    set_req(1, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL burst_idle_after: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp_g [8];
    logic [31:0] exp_a;
    exp_g = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h0000_0100);
    set_req(1, 1'b1, 1'b0, 1'b0, 32'h0000_0200);
    bus.mem_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cyc();
      exp_a = (exp_g[c] == 2'b01) ? 32'h100 : (exp_g[c] == 2'b10) ? 32'h200 : 32'h0;
      checks++;
      if (bus.req_grant !== exp_g[c] || bus.req_done !== exp_g[c] ||
          bus.mem_read !== (exp_g[c] != 2'b00) || bus.mem_addr !== exp_a) begin
        errors++;
        $display("FAIL b2b_cycle%0d: got grant=%b done=%b rd=%b addr=%h expected grant=%b done=%b rd=%b addr=%h",
                 c, bus.req_grant, bus.req_done, bus.mem_read, bus.mem_addr,
                 exp_g[c], exp_g[c], (exp_g[c] != 2'b00), exp_a);
      end
      if (c == 6) begin
        bus.req_valid = 2'b00;
      end
    end
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_write_burst();
    int wcnt   = 0;
    int rcnt   = 0;
    int done_c = 0;
    set_req(0, 1'b1, 1'b1, 1'b1, 32'h0000_2008);
    bus.mem_ready = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      if (bus.mem_write === 1'b1) wcnt++;
      if (bus.mem_read === 1'b1) rcnt++;
      checks++;
      if ({bus.mem_write, bus.beat_valid} !== {(c <= 4), (c <= 4)}) begin
        errors++;
        $display("FAIL wburst_strobe_c%0d: got wr/bv=%b expected %b",
                 c, {bus.mem_write, bus.beat_valid}, {(c <= 4), (c <= 4)});
      end
      if (c <= 4) begin
        checks++;
        if (bus.mem_addr !== 32'h0000_2000 + 32'((c - 1) * 4)) begin
          errors++;
          $display("FAIL wburst_addr_c%0d: got %h expected %h", c, bus.mem_addr, 32'h0000_2000 + 32'((c - 1) * 4));
        end
      end
      if (bus.req_done[0] === 1'b1) begin
        done_c = c;
        set_req(0, 1'b0, 1'b0, 1'b0, 32'h0);
      end
    end
    bus.mem_ready = 1'b0;
    checks++;
    if (wcnt != 4 || rcnt != 0 || done_c != 4) begin
      errors++;
      $display("FAIL wburst_summary: got writes=%0d reads=%0d done_cycle=%0d expected writes=4 reads=0 done_cycle=4",
               wcnt, rcnt, done_c);
    end
  endtask

  task automatic test_reset_mid_burst();
    set_req(1, 1'b1, 1'b0, 1'b1, 32'h0000_5550);
    bus.mem_ready = 1'b1;
    cyc();
    checks++;
    if ({bus.req_grant, bus.beat_idx, bus.beat_valid} !== 5'b10_00_1) begin
      errors++;
      $display("FAIL rstmid_beat0: got %b expected %b", {bus.req_grant, bus.beat_idx, bus.beat_valid}, 5'b10_00_1);
    end
    cyc();
    checks++;
    if ({bus.beat_idx, bus.req_done} !== 4'b01_00) begin
      errors++;
      $display("FAIL rstmid_beat1: got %b expected %b", {bus.beat_idx, bus.req_done}, 4'b01_00);
    end
    rst = 1'b1;
    cyc();
    checks++;
    if ({bus.req_grant, bus.req_done, bus.beat_valid, bus.mem_read, bus.mem_write, bus.busy} !== 8'b0 ||
        bus.mem_addr !== 32'h0 || bus.beat_idx !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_abort: got ctrl=%b addr=%h idx=%0d expected ctrl=00000000 addr=00000000 idx=0",
               {bus.req_grant, bus.req_done, bus.beat_valid, bus.mem_read, bus.mem_write, bus.busy},
               bus.mem_addr, bus.beat_idx);
    end
    rst           = 1'b0;
    bus.mem_ready = 1'b0;
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h0000_0300);
    cyc();
    checks++;
    if (bus.req_grant !== 2'b01 || bus.mem_addr !== 32'h300 || bus.beat_idx !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_regrant: got grant=%b addr=%h idx=%0d expected grant=01 addr=00000300 idx=0",
               bus.req_grant, bus.mem_addr, bus.beat_idx);
    end
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_done !== 2'b01) begin
      errors++;
      $display("FAIL rstmid_single_done: got %b expected 01", bus.req_done);
    end
    cyc();
    bus.mem_ready = 1'b0;
    bus.req_valid = 2'b00;
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_idle_after: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_withdraw();
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h0000_0040);
    cyc();
    set_req(0, 1'b0, 1'b0, 1'b0, 32'h0);
    set_req(1, 1'b1, 1'b1, 1'b0, 32'h0000_0084);
    cyc();
    checks++;
    if ({bus.req_grant, bus.mem_read, bus.busy} !== 4'b0111 || bus.mem_addr !== 32'h40) begin
      errors++;
      $display("FAIL withdraw_hold: got ctrl=%b addr=%h expected ctrl=0111 addr=00000040",
               {bus.req_grant, bus.mem_read, bus.busy}, bus.mem_addr);
    end
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_done !== 2'b01) begin
      errors++;
      $display("FAIL withdraw_done: got %b expected 01", bus.req_done);
    end
    cyc();
    bus.mem_ready = 1'b0;
    #1;
    checks++;
    if ({bus.req_grant, bus.mem_read, bus.mem_write, bus.busy} !== 5'b0) begin
      errors++;
      $display("FAIL withdraw_turnaround: got %b expected 00000",
               {bus.req_grant, bus.mem_read, bus.mem_write, bus.busy});
    end
    cyc();
    checks++;
    if ({bus.req_grant, bus.mem_write, bus.mem_read} !== 4'b1010 || bus.mem_addr !== 32'h84) begin
      errors++;
      $display("FAIL withdraw_next_grant: got ctrl=%b addr=%h expected ctrl=1010 addr=00000084",
               {bus.req_grant, bus.mem_write, bus.mem_read}, bus.mem_addr);
    end
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_done !== 2'b10) begin
      errors++;
      $display("FAIL withdraw_next_done: got %b expected 10", bus.req_done);
    end
    cyc();
    set_req(1, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    checks++;
    if ({bus.busy, bus.beat_valid} !== 2'b00) begin
      errors++;
      $display("FAIL idle_ignores_ready: got busy/bv=%b expected 00", {bus.busy, bus.beat_valid});
    end
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_burst_refill();
    test_back_to_back();
    test_write_burst();
    test_reset_mid_burst();
    test_withdraw();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single main-memory port between NUM_REQ cache-side requesters, for example the data-cache controller's refill/write-through path and an instruction-cache refill path.
- Arbitrates round-robin and owns the memory read/write strobes and address.
- Sequences either single-word or full-line (BURST_LEN beats) transfers, one beat per mem_ready.
- Sits between the cache controllers and main memory.

Parameters:
- WIDTH, 32, address width in bits.
- NUM_REQ, 2, number of requesters; legal range 2..8.
- OFFSET_BITS, 4, line-offset bits; line = 16 bytes.
- BURST_LEN, 4, beats per line transfer; BURST_LEN*4 == 2**OFFSET_BITS.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request; held high until that requester's req_done.
- req_write  in  NUM_REQ  1 = write, 0 = read; sampled at grant.
- req_burst  in  NUM_REQ  1 = line burst of BURST_LEN beats, 0 = single beat; sampled at grant.
- req_addr  in  NUM_REQ*WIDTH  packed byte addresses; requester i occupies [i*WIDTH +: WIDTH].
- req_grant  out  NUM_REQ  one-hot, high for the whole owned transaction.
- req_done  out  NUM_REQ  one-cycle pulse to the owner on its last beat.
- beat_valid  out  1  high in the cycle a beat completes (XFER && mem_ready).
- beat_idx  out  $clog2(BURST_LEN)  index of the current beat.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  WIDTH  word address of the current beat.
- mem_ready  in  1  memory completes the current beat this cycle.
- busy  out  1  high when state != IDLE.

Behaviour:
- States: IDLE, XFER. Encoding lives in the package.
- Reset (rst high at posedge):
  - state=IDLE; rr_ptr=0; beat counter=0.
  - req_grant, req_done, beat_valid, mem_read, mem_write and busy are all 0; mem_addr=0.
  - Reset mid-transfer aborts immediately; strobes are low in the cycle after the reset edge. No req_done is issued for the aborted transaction.
- IDLE:
  - If any req_valid, select the winner: the first asserted bit scanning from rr_ptr upward, modulo NUM_REQ.
  - At the edge, register the one-hot grant, the winner's write and burst flags, and its base address.
  - Base address: the burst base has the low OFFSET_BITS forced to 0; the single-beat base has only bits [1:0] forced to 0.
  - Go to XFER.
  - With no request, stay in IDLE with all outputs 0.
- Latency: req_valid first high in cycle t gives req_grant and mem strobe high from cycle t+1.
- XFER:
  - mem_read = ~wr_q and mem_write = wr_q; exactly one is high.
  - mem_addr = base | (beat_cnt << 2). beat_cnt stays within the line, so there is no carry into the tag/index bits.
  - beat_idx = beat_cnt.
  - Strobes and address hold stable until mem_ready.
  - On mem_ready with a non-last beat: beat_valid=1; beat_cnt increments.
  - On mem_ready with the last beat (beat_cnt == BURST_LEN-1 for bursts, 0 for singles):
    - beat_valid=1, and req_done pulses for the grant owner.
    - Next state is IDLE; beat_cnt clears to 0; req_grant drops.
    - rr_ptr <= (owner+1) mod NUM_REQ.
- Turnaround: one IDLE cycle is mandatory between transactions. A back-to-back next strobe rises 2 cycles after the prior req_done.
- Deasserting req_valid during XFER is ignored; the transfer completes.
- New requests arriving during XFER wait; they are arbitrated only in IDLE.
- mem_ready is ignored outside XFER.
- mem_ready held high continuously completes one beat per cycle. A burst then takes BURST_LEN cycles in XFER.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 transactions.

Decomposition:
- Package cache_pkg holds:
  - WIDTH, OFFSET_BITS, BURST_LEN and BEAT_BYTES=4 constants.
  - The arbiter state enum {IDLE, XFER}.
  - The beat-counter width function/constant.
- One sub-module, rr_arbiter: combinational round-robin pick. Inputs: request vector and rr_ptr. Outputs: one-hot grant and encoded index.
- The FSM, beat counter and registers stay in mem_port_arbiter.

Test Plan:
- Single read: req0 asserts valid (write=0, burst=0, addr=0x1236), mem_ready after 3 cycles. Required: mem_addr=0x1234; mem_read high 3 cycles, then beat_valid and req_done[0]; busy low next cycle.
- Burst refill: req1 asserts valid (write=0, burst=1, addr=0x0000_ABCC), mem_ready every 2nd cycle. Required: mem_addr steps 0xABC0, 0xABC4, 0xABC8, 0xABCC; beat_idx runs 0..3; req_done[1] on the 4th beat only.
- Contention: req0 and req1 both asserted continuously with single beats, rr_ptr=0. Required: grant order 0,1,0,1, with exactly one IDLE cycle between each req_done and the next strobe.
- Write burst with mem_ready tied high: req0 asserts valid (write=1, burst=1). Required: mem_write high exactly 4 consecutive cycles, mem_read never high, req_done[0] in cycle 4.
- Reset mid-burst: assert rst after beat 1 of a req1 burst. Required: next cycle all outputs 0 and state IDLE, no req_done. After reset, simultaneous req0 and req1 grant req0 (rr_ptr=0).
- Withdraw: req0 drops valid during XFER. Required: the transfer still completes and req_done[0] still pulses.
